// File: rtl/prog_loader.sv
// Program loader: parses a byte stream of IMEM/DMEM load frames plus run/stop commands
// and drives the two memory write ports. PROG_LOADER_CHECKSUM_EN adds a trailing XOR byte per frame.
module prog_loader #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic [31:0]       wdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic [63:0]       wdata_ext_2,
  output logic              enable,
  output logic              busy,
  output logic              error
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_LO = 4'd1,
    ADDR_HI = 4'd2,
    LEN_LO  = 4'd3,
    LEN_HI  = 4'd4,
    DATA    = 4'd5,
    WRITE   = 4'd6,
`ifdef PROG_LOADER_CHECKSUM_EN
    CSUM    = 4'd7,
`endif
    RUN     = 4'd8,
    ERR     = 4'd9
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
  logic [7:0] csum;
`else
  localparam state_t END_ST = IDLE;
`endif

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  cnt;
  logic [63:0]       word;
  logic [2:0]        bcnt;
  logic              dmem;
  logic              accept;
  logic              last_byte;
  logic [63:0]       wd_s;

  assign accept    = in_valid && in_ready;
  assign last_byte = (bcnt == (dmem ? 3'd7 : 3'd3));
  // Word as it will look once the byte on the bus is merged in (little-endian).
  assign wd_s      = word | ({56'd0, in_data} << {bcnt, 3'b000});

  // Next-state decode.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (!accept) begin
          nxt = IDLE;
        end else if (in_data == 8'h01 || in_data == 8'h02) begin
          nxt = ADDR_LO;
        end else if (in_data == 8'h03) begin
          nxt = RUN;
        end else begin
          nxt = ERR;
        end
      end
      ADDR_LO: if (accept) nxt = ADDR_HI; else nxt = ADDR_LO;
      ADDR_HI: if (accept) nxt = LEN_LO;  else nxt = ADDR_HI;
      LEN_LO:  if (accept) nxt = LEN_HI;  else nxt = LEN_LO;
      LEN_HI: begin
        if (!accept) begin
          nxt = LEN_HI;
        end else if ({in_data, cnt[7:0]} == 16'd0) begin
          nxt = END_ST;
        end else begin
          nxt = DATA;
        end
      end
      DATA: if (accept && last_byte) nxt = WRITE; else nxt = DATA;
      WRITE: if (cnt == LEN_W'(1)) nxt = END_ST; else nxt = DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (!accept) begin
          nxt = CSUM;
        end else if (in_data == csum) begin
          nxt = IDLE;
        end else begin
          nxt = ERR;
        end
      end
`endif
      RUN: if (accept && in_data == 8'h00) nxt = IDLE; else nxt = RUN;
      ERR: nxt = ERR;
      default: nxt = ERR;
    endcase
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      addr_r      <= '0;
      cnt         <= '0;
      word        <= 64'd0;
      bcnt        <= 3'd0;
      dmem        <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      enable      <= 1'b0;
      error       <= 1'b0;
      wen_ext     <= 1'b0;
      wen_ext_2   <= 1'b0;
      addr_ext    <= '0;
      addr_ext_2  <= '0;
      wdata_ext   <= 32'd0;
      wdata_ext_2 <= 64'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum        <= 8'd0;
`endif
    end else begin
      state     <= nxt;
      in_ready  <= (nxt != WRITE) && (nxt != ERR);
      busy      <= (nxt != IDLE) && (nxt != RUN) && (nxt != ERR);
      enable    <= (nxt == RUN);
      error     <= (nxt == ERR);
      wen_ext   <= (nxt == WRITE) && !dmem;
      wen_ext_2 <= (nxt == WRITE) && dmem;
      if (nxt == WRITE && !dmem) begin
        addr_ext  <= addr_r;
        wdata_ext <= wd_s[31:0];
      end
      if (nxt == WRITE && dmem) begin
        addr_ext_2  <= addr_r;
        wdata_ext_2 <= wd_s;
      end
      if (accept) begin
        case (state)
          IDLE: begin
            dmem   <= (in_data == 8'h02);
            addr_r <= '0;
            cnt    <= '0;
            word   <= 64'd0;
            bcnt   <= 3'd0;
          end
          ADDR_LO: addr_r[7:0]        <= in_data;
          ADDR_HI: addr_r[15:8]       <= in_data;
          LEN_LO:  cnt[7:0]           <= in_data;
          LEN_HI:  cnt[LEN_W-1:8]     <= in_data;
          DATA: begin
            word <= wd_s;
            bcnt <= last_byte ? 3'd0 : bcnt + 3'd1;
          end
          default: ;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        csum <= (state == IDLE) ? in_data : (csum ^ in_data);
`endif
      end
      if (state == WRITE) begin
        addr_r <= addr_r + (dmem ? ADDR_W'(8) : ADDR_W'(4));
        cnt    <= cnt - LEN_W'(1);
        word   <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames are expanded into expected writes by a
// frame-level model; a monitor pops and compares on every write pulse.
module tb_prog_loader;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              srst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic [ADDR_W-1:0] addr_ext;
  logic              wen_ext;
  logic [31:0]       wdata_ext;
  logic [ADDR_W-1:0] addr_ext_2;
  logic              wen_ext_2;
  logic [63:0]       wdata_ext_2;
  logic              enable;
  logic              busy;
  logic              error;

  prog_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
    .enable(enable), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] wbuf[$];
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!srst && (wen_ext || wen_ext_2)) begin
      wr_t e;
      chk("one_wen", 64'(wen_ext && wen_ext_2), 64'd0);
      chk("ready_in_write", 64'(in_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_port", 64'(wen_ext_2), 64'(e.dm));
        if (e.dm) begin
          chk("dmem_addr", addr_ext_2, e.addr);
          chk("dmem_data", wdata_ext_2, e.data);
        end else begin
          chk("imem_addr", addr_ext, e.addr);
          chk("imem_data", 64'(wdata_ext), e.data);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Frame-level model: n words from wbuf, consecutive addresses, optional checksum.
  task automatic send_frame(input bit dm, input logic [15:0] a, input int n, input bit bad_csum);
    logic [7:0]  x;
    logic [7:0]  hdr[5];
    int          nb;
    logic [63:0] w;
    wr_t         e;
    nb = dm ? 8 : 4;
    hdr[0] = dm ? 8'h02 : 8'h01;
    hdr[1] = a[7:0];
    hdr[2] = a[15:8];
    hdr[3] = 8'(n);
    hdr[4] = 8'(n >> 8);
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      e.dm   = dm;
      e.addr = 64'(a) + 64'(i * nb);
      e.data = dm ? wbuf[i] : (wbuf[i] & 64'h0000_0000_FFFF_FFFF);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      x ^= hdr[i];
      send_byte(hdr[i]);
      gap();
    end
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      for (int j = 0; j < nb; j++) begin
        x ^= w[7:0];
        send_byte(w[7:0]);
        w = w >> 8;
        if (j == nb - 1) chk("wen_latency", 64'(wen_ext || wen_ext_2), 64'd1);
        gap();
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~x : x);
`else
    if (bad_csum) x = 8'd0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_wen", 64'({wen_ext, wen_ext_2}), 64'd0);
    chk("rst_status", 64'({enable, busy, error, in_ready}), 64'b0001);
    srst = 1'b0;
    @(negedge clk);
    chk("post_rst_status", 64'({enable, busy, error, in_ready, wen_ext, wen_ext_2}), 64'b000100);
    chk("post_rst_addr", addr_ext | addr_ext_2, 64'd0);
    chk("post_rst_wdata", 64'(wdata_ext) | wdata_ext_2, 64'd0);
  endtask

  task automatic idle_check(input string name);
    repeat (2) @(negedge clk);
    chk(name, 64'({busy, error, enable, in_ready}), 64'b0001);
  endtask

  initial begin
    do_reset();

    // Single IMEM word at address 0.
    wbuf = '{64'h0000_0000_0000_0013};
    send_frame(1'b0, 16'h0000, 1, 1'b0);
    idle_check("imem_idle");

    // Two DMEM words starting at 0x8.
    wbuf = '{64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_F001};
    send_frame(1'b1, 16'h0008, 2, 1'b0);
    idle_check("dmem_idle");

    // Run / stop.
    send_byte(8'h03);
    chk("run_enable", 64'({enable, busy, in_ready}), 64'b101);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom_range(1, 255)));
      chk("run_hold", 64'(enable), 64'd1);
    end
    send_byte(8'h00);
    chk("stop_enable", 64'({enable, busy, in_ready}), 64'b001);

    // Randomized frames, including zero-length ones.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(0, 3);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back({$urandom, $urandom});
      send_frame(1'($urandom_range(0, 1)), 16'($urandom), n, 1'b0);
      idle_check("rand_idle");
    end

    // Illegal command is sticky until reset.
    send_byte(8'h7F);
    chk("err_flag", 64'({error, in_ready, enable, busy}), 64'b1000);
    repeat (5) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'({error, in_ready}), 64'b10);
    do_reset();

    // Reset after the 3rd data byte must suppress the pending write.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    do_reset();
    repeat (3) @(negedge clk);
    chk("abort_no_write", 64'(exp_q.size()), 64'd0);
    wbuf = '{64'h0000_0000_CAFE_F00D};
    send_frame(1'b0, 16'h0100, 1, 1'b0);
    idle_check("after_abort_idle");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum: write still lands, then sticky error.
    wbuf = '{64'h0000_0000_DDCC_BBAA};
    send_frame(1'b0, 16'h0004, 1, 1'b1);
    @(negedge clk);
    chk("csum_err", 64'({error, in_ready}), 64'b10);
    do_reset();
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 64, meaning the width of both memory address outputs.
REQ-002 The block SHALL provide parameter LEN_W, default 16, meaning the width of the frame word-count field; LEN_W is fixed at 16 in this revision.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port srst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1): byte stream; a byte transfers when in_valid and in_ready are both high on a rising edge.
REQ-007 The block SHALL have ports addr_ext (output, ADDR_W), wen_ext (output, 1) and wdata_ext (output, 32): instruction-memory external write port.
REQ-008 The block SHALL have ports addr_ext_2 (output, ADDR_W), wen_ext_2 (output, 1) and wdata_ext_2 (output, 64): data-memory external write port.
REQ-009 The block SHALL have port enable, output, 1 bit: CPU run enable.
REQ-010 The block SHALL have ports busy (output, 1) and error (output, 1): status flags.

Function
REQ-011 Frame format: CMD byte; for CMD 0x01 (IMEM) or 0x02 (DMEM), ADDR[15:0] then LEN[15:0] (both LSB first), then LEN words, each LSB first (4 bytes for IMEM, 8 bytes for DMEM).
REQ-012 The FSM SHALL have states IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, WRITE, CSUM, RUN and ERR.
REQ-013 In IDLE: CMD 0x01 or 0x02 -> ADDR_LO; 0x03 -> RUN; any other value -> ERR.
REQ-014 Headers SHALL advance ADDR_LO -> ADDR_HI -> LEN_LO -> LEN_HI on each accepted byte. From LEN_HI: LEN=0 -> CSUM if REQ-028 compiled, else IDLE, with no write; otherwise -> DATA.
REQ-015 DATA SHALL assemble bytes little-endian. After the 4th byte (IMEM) or 8th byte (DMEM) it SHALL go to WRITE.
REQ-016 WRITE SHALL last exactly one cycle: wen_ext or wen_ext_2 high, the matching address equal to the current byte address (zero-extended ADDR on the first word), and data equal to the assembled word.
REQ-017 Write latency: wen SHALL be high in the cycle immediately after the edge that accepted the word's last byte.
REQ-018 After each write the address SHALL advance by 4 (IMEM) or 8 (DMEM) modulo 2^ADDR_W, and the remaining count SHALL decrement. Count nonzero -> DATA; count zero -> CSUM or IDLE.
REQ-019 in_ready SHALL be 1 in IDLE, ADDR_*, LEN_*, DATA, CSUM and RUN, and 0 in WRITE and ERR.
REQ-020 Only one of wen_ext and wen_ext_2 SHALL be high in any cycle, and only in WRITE; wdata/addr outputs SHALL hold their values outside WRITE.
REQ-021 RUN: enable=1. CMD 0x00 -> IDLE with enable=0 the next cycle; other bytes SHALL be accepted and ignored.
REQ-022 ERR SHALL be sticky: error=1, in_ready=0, enable=0 until srst.
REQ-023 busy SHALL be 1 in every state except IDLE, RUN and ERR.
REQ-024 Writes already issued before an error SHALL NOT be undone.

Reset
REQ-025 When srst is high at a rising edge, the FSM SHALL go to IDLE and all counters, the address register and the data register SHALL clear to 0.
REQ-026 While in reset, and in the first cycle after it: wen_ext=0, wen_ext_2=0, enable=0, busy=0, error=0, addr outputs=0, wdata outputs=0, in_ready=1.
REQ-027 srst asserted mid-frame or during RUN SHALL abort immediately: a pending WRITE SHALL NOT occur and the partial frame SHALL be discarded.

Configuration
REQ-028 Macro PROG_LOADER_CHECKSUM_EN defined: every IMEM/DMEM frame SHALL end with one checksum byte equal to the XOR of all preceding frame bytes (CMD included). Match -> IDLE; mismatch -> ERR.
REQ-029 Macro PROG_LOADER_CHECKSUM_EN undefined: the CSUM state and the XOR register SHALL be absent, and frames SHALL end after the last data word.

Verification
REQ-030 Bytes 01 00 00 01 00 13 00 00 00 (no checksum) -> one wen_ext pulse with addr_ext=0x0, wdata_ext=0x00000013, then back to IDLE.
REQ-031 DMEM frame 02 08 00 02 00 followed by 16 data bytes -> wen_ext_2 pulses at addr 0x8 then 0x10 with the correct 64-bit words, and in_ready=0 during each pulse.
REQ-032 Byte 03 -> enable=1 the next cycle; then byte 00 -> enable=0 and state IDLE.
REQ-033 Byte 0x7F in IDLE -> error=1 and in_ready=0, held until srst; after srst, error=0.
REQ-034 srst asserted after the 3rd data byte of an IMEM word -> no wen_ext ever issued; a following valid frame writes correctly.
REQ-035 Macro defined, frame 01 04 00 01 00 AA BB CC DD with a wrong checksum byte -> the write at 0x4 occurs, then error=1.
